mul_dispatch_unit: RTL and testbench

Issue/writeback controller for the sequential unsigned multiplier. It accepts MUL requests from the decode stage through a valid/ready handshake and latches operands and destination register. It then either short-circuits trivial operands or drives the multiplier's start/operand inputs and waits for its done. The 8-bit product is returned as a one-cycle writeback pulse to the register file, and the unit stalls upstream while busy.

---
 rtl/mul_pkg.sv | 16 +
 rtl/mul_dispatch_unit.sv | 142 ++++++++++++++
 tb/tb_mul_dispatch_unit.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mul_pkg.sv
// Shared definitions for the multiply dispatch path.
// Holds the controller state encoding and default datapath sizes.
package mul_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_WAIT  = 2'd2,
      S_WB    = 2'd3
   } mul_state_t;

   localparam int DEF_WIDTH   = 8;
   localparam int DEF_DEST_W  = 3;
   localparam int DEF_TIMEOUT = 32;

endpackage

// File: rtl/mul_dispatch_unit.sv
// Issue/writeback controller for the sequential unsigned multiplier.
// Short-circuits trivial operands; otherwise starts the multiplier and waits for a fresh done edge.
module mul_dispatch_unit
   import mul_pkg::*;
#(
   parameter int WIDTH   = DEF_WIDTH,
   parameter int DEST_W  = DEF_DEST_W,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [WIDTH-1:0]  req_a,
   input  logic [WIDTH-1:0]  req_b,
   input  logic [DEST_W-1:0] req_dest,
   output logic              busy,
   output logic              mul_start,
   output logic [WIDTH-1:0]  mul_a,
   output logic [WIDTH-1:0]  mul_b,
   input  logic [WIDTH-1:0]  mul_result,
   input  logic              mul_done,
   output logic              wb_valid,
   output logic [WIDTH-1:0]  wb_data,
   output logic [DEST_W-1:0] wb_dest,
   output logic              wb_err
);

   localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

   mul_state_t        r_state;
   logic [WIDTH-1:0]  r_a;
   logic [WIDTH-1:0]  r_b;
   logic [DEST_W-1:0] r_dest;
   logic [TW-1:0]     r_timer;
   logic              r_done_q;
   logic              r_mul_start;
   logic              r_wb_valid;
   logic [WIDTH-1:0]  r_wb_data;
   logic [DEST_W-1:0] r_wb_dest;
   logic              r_wb_err;

   logic              w_done_edge;
   logic              w_bypass;
   logic [WIDTH-1:0]  w_bypass_res;

   // Only a rising edge counts, so a level done left over from the previous op is never taken.
   assign w_done_edge = mul_done & ~r_done_q;

   always_comb begin
      w_bypass     = 1'b1;
      w_bypass_res = '0;
      if (req_a == '0 || req_b == '0) begin
         w_bypass_res = '0;
      end else if (req_a == WIDTH'(1)) begin
         w_bypass_res = req_b;
      end else if (req_b == WIDTH'(1)) begin
         w_bypass_res = req_a;
      end else begin
         w_bypass = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_a         <= '0;
         r_b         <= '0;
         r_dest      <= '0;
         r_timer     <= '0;
         r_done_q    <= 1'b0;
         r_mul_start <= 1'b0;
         r_wb_valid  <= 1'b0;
         r_wb_data   <= '0;
         r_wb_dest   <= '0;
         r_wb_err    <= 1'b0;
      end else begin
         r_done_q    <= mul_done;
         r_mul_start <= 1'b0;
         r_wb_valid  <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (req_valid) begin
                  r_a    <= req_a;
                  r_b    <= req_b;
                  r_dest <= req_dest;
                  if (w_bypass) begin
                     r_wb_data  <= w_bypass_res;
                     r_wb_dest  <= req_dest;
                     r_wb_err   <= 1'b0;
                     r_wb_valid <= 1'b1;
                     r_state    <= S_WB;
                  end else begin
                     r_mul_start <= 1'b1;
                     r_state     <= S_START;
                  end
               end
            end
            S_START: begin
               r_timer <= '0;
               r_state <= S_WAIT;
            end
            S_WAIT: begin
               // Completion is checked before expiry so a same-cycle done still succeeds.
               if (w_done_edge) begin
                  r_wb_data  <= mul_result;
                  r_wb_dest  <= r_dest;
                  r_wb_err   <= 1'b0;
                  r_wb_valid <= 1'b1;
                  r_state    <= S_WB;
               end else if (r_timer == TIMER_LAST) begin
                  r_wb_data  <= '0;
                  r_wb_dest  <= r_dest;
                  r_wb_err   <= 1'b1;
                  r_wb_valid <= 1'b1;
                  r_state    <= S_WB;
               end else begin
                  r_timer <= r_timer + TW'(1);
               end
            end
            S_WB: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign req_ready = (r_state == S_IDLE);
   assign busy      = (r_state != S_IDLE);
   assign mul_start = r_mul_start;
   assign mul_a     = r_a;
   assign mul_b     = r_b;
   assign wb_valid  = r_wb_valid;
   assign wb_data   = r_wb_data;
   assign wb_dest   = r_wb_dest;
   assign wb_err    = r_wb_err;

endmodule

// File: tb/tb_mul_dispatch_unit.sv
// Directed testbench for mul_dispatch_unit with a behavioural multiplier model
// (programmable latency, pulse or level done, or never done).
module tb_mul_dispatch_unit;

   logic       clk;
   logic       rst;
   logic       req_valid;
   logic       req_ready;
   logic [7:0] req_a;
   logic [7:0] req_b;
   logic [2:0] req_dest;
   logic       busy;
   logic       mul_start;
   logic [7:0] mul_a;
   logic [7:0] mul_b;
   logic [7:0] mul_result;
   logic       mul_done;
   logic       wb_valid;
   logic [7:0] wb_data;
   logic [2:0] wb_dest;
   logic       wb_err;

   int tests_run;
   int tests_failed;
   int start_count;

   // multiplier model controls
   int         m_lat;
   logic       m_level;
   logic       m_never;
   int         m_cnt;
   logic       m_act;
   logic [7:0] m_prod;
   logic [15:0] m_full;

   mul_dispatch_unit #(.WIDTH(8), .DEST_W(3), .TIMEOUT(32)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_dest(req_dest),
      .busy(busy), .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
      .mul_result(mul_result), .mul_done(mul_done),
      .wb_valid(wb_valid), .wb_data(wb_data), .wb_dest(wb_dest), .wb_err(wb_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign m_full = mul_a * mul_b;

   always @(posedge clk) begin
      if (rst) begin
         mul_done   <= 1'b0;
         mul_result <= 8'd0;
         m_cnt      <= 0;
         m_act      <= 1'b0;
         m_prod     <= 8'd0;
      end else begin
         if (!m_level && mul_done) mul_done <= 1'b0;
         if (mul_start && !m_never) begin
            m_act  <= 1'b1;
            m_cnt  <= m_lat;
            m_prod <= m_full[7:0];
         end else if (m_act) begin
            if (m_cnt > 1) begin
               if (m_cnt == 2) mul_done <= 1'b0;
               m_cnt <= m_cnt - 1;
            end else begin
               mul_done   <= 1'b1;
               mul_result <= m_prod;
               m_act      <= 1'b0;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (mul_start === 1'b1) start_count++;
   end

   // Presents a request and returns at the negedge of the cycle after the accept edge.
   task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [2:0] d);
      int n;
      @(negedge clk);
      req_valid = 1'b1;
      req_a     = a;
      req_b     = b;
      req_dest  = d;
      n = 0;
      while (req_ready !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) begin
         tests_run++;
         tests_failed++;
         $display("FAIL issue_timeout: req_ready never high");
      end
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   // Counts cycles from the first post-accept cycle (=1) up to the wb_valid cycle.
   task automatic wait_wb(output int cyc, input logic chk_ops, input logic [7:0] ea, input logic [7:0] eb);
      cyc = 1;
      while (wb_valid !== 1'b1 && cyc < 100) begin
         if (chk_ops) begin
            tests_run++;
            if (mul_a !== ea || mul_b !== eb) begin
               tests_failed++;
               $display("FAIL operand_hold: cycle %0d mul_a=%0d mul_b=%0d want %0d %0d", cyc, mul_a, mul_b, ea, eb);
            end
         end
         @(negedge clk);
         cyc++;
      end
      if (cyc >= 100) begin
         tests_run++;
         tests_failed++;
         $display("FAIL wb_timeout: no wb_valid within bound");
      end
   endtask

   task automatic check_wb(input string name, input int cyc, input int ecyc,
                           input logic [7:0] ed, input logic [2:0] edest, input logic eerr);
      tests_run++;
      if (cyc !== ecyc || wb_data !== ed || wb_dest !== edest || wb_err !== eerr) begin
         tests_failed++;
         $display("FAIL %s: cyc=%0d data=%0d dest=%0d err=%0d want cyc=%0d data=%0d dest=%0d err=%0d",
                  name, cyc, wb_data, wb_dest, wb_err, ecyc, ed, edest, eerr);
      end else begin
         $display("[TB] %s: data=%0d dest=%0d err=%0d at cycle %0d", name, wb_data, wb_dest, wb_err, cyc);
      end
      @(negedge clk);
      tests_run++;
      if (wb_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1 || wb_data !== ed) begin
         tests_failed++;
         $display("FAIL %s_after: wb_valid=%0b busy=%0b ready=%0b data=%0d want 0 0 1 %0d",
                  name, wb_valid, busy, req_ready, wb_data, ed);
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      tests_run++;
      if (req_ready !== 1'b1 || busy !== 1'b0 || mul_start !== 1'b0 || wb_valid !== 1'b0 ||
          wb_err !== 1'b0 || mul_a !== 8'd0 || mul_b !== 8'd0 || wb_data !== 8'd0 || wb_dest !== 3'd0) begin
         tests_failed++;
         $display("FAIL reset: ready=%0b busy=%0b start=%0b wbv=%0b err=%0b a=%0d b=%0d data=%0d dest=%0d want 1 0 0 0 0 0 0 0 0",
                  req_ready, busy, mul_start, wb_valid, wb_err, mul_a, mul_b, wb_data, wb_dest);
      end else begin
         $display("[TB] reset: outputs at reset values");
      end
   endtask

   task automatic test_basic_mul;
      int cyc;
      m_lat = 8; m_level = 1'b0; m_never = 1'b0;
      start_count = 0;
      issue(8'd5, 8'd3, 3'd2);
      tests_run++;
      if (mul_start !== 1'b1 || busy !== 1'b1) begin
         tests_failed++;
         $display("FAIL start_pulse: mul_start=%0b busy=%0b want 1 1", mul_start, busy);
      end
      wait_wb(cyc, 1'b1, 8'd5, 8'd3);
      check_wb("mul_5x3", cyc, 11, 8'd15, 3'd2, 1'b0);
      tests_run++;
      if (start_count !== 1) begin
         tests_failed++;
         $display("FAIL start_count: %0d want 1", start_count);
      end
   endtask

   task automatic test_back_to_back;
      int cyc;
      m_lat = 6; m_level = 1'b1; m_never = 1'b0;
      issue(8'd12, 8'd10, 3'd4);
      wait_wb(cyc, 1'b0, 8'd0, 8'd0);
      check_wb("b2b_12x10", cyc, 9, 8'd120, 3'd4, 1'b0);
      issue(8'd255, 8'd2, 3'd6);
      wait_wb(cyc, 1'b0, 8'd0, 8'd0);
      check_wb("b2b_255x2", cyc, 9, 8'd254, 3'd6, 1'b0);
      m_level = 1'b0;
   endtask

   task automatic test_bypass;
      logic [7:0] va [3];
      logic [7:0] vb [3];
      logic [7:0] vr [3];
      int cyc;
      va = '{8'd0, 8'd1, 8'd9};
      vb = '{8'd50, 8'd77, 8'd1};
      vr = '{8'd0, 8'd77, 8'd9};
      start_count = 0;
      for (int i = 0; i < 3; i++) begin
         issue(va[i], vb[i], 3'(i + 1));
         tests_run++;
         if (busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL bypass_busy%0d: busy=%0b want 1", i, busy);
         end
         wait_wb(cyc, 1'b0, 8'd0, 8'd0);
         check_wb($sformatf("bypass%0d", i), cyc, 1, vr[i], 3'(i + 1), 1'b0);
      end
      tests_run++;
      if (start_count !== 0) begin
         tests_failed++;
         $display("FAIL bypass_nostart: mul_start pulses=%0d want 0", start_count);
      end
   endtask

   task automatic test_timeout;
      int cyc;
      m_never = 1'b1;
      issue(8'd3, 8'd4, 3'd5);
      wait_wb(cyc, 1'b1, 8'd3, 8'd4);
      check_wb("timeout_3x4", cyc, 34, 8'd0, 3'd5, 1'b1);
      m_never = 1'b0; m_lat = 4;
      issue(8'd2, 8'd2, 3'd3);
      wait_wb(cyc, 1'b0, 8'd0, 8'd0);
      check_wb("after_timeout_2x2", cyc, 7, 8'd4, 3'd3, 1'b0);
   endtask

   task automatic test_reset_in_wait;
      int cyc;
      int seen;
      m_lat = 8;
      issue(8'd6, 8'd7, 3'd1);
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      tests_run++;
      if (req_ready !== 1'b1 || busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL rst_wait_ready: ready=%0b busy=%0b want 1 0", req_ready, busy);
      end
      seen = 0;
      for (int i = 0; i < 15; i++) begin
         if (wb_valid === 1'b1) seen++;
         @(negedge clk);
      end
      tests_run++;
      if (seen !== 0) begin
         tests_failed++;
         $display("FAIL rst_wait_nowb: wb_valid cycles=%0d want 0", seen);
      end else begin
         $display("[TB] rst_wait: in-flight op discarded");
      end
      issue(8'd6, 8'd7, 3'd1);
      wait_wb(cyc, 1'b0, 8'd0, 8'd0);
      check_wb("after_rst_6x7", cyc, 11, 8'd42, 3'd1, 1'b0);
   endtask

   task automatic test_hold_during_busy;
      int cyc;
      m_lat = 5;
      issue(8'd7, 8'd9, 3'd7);
      req_valid = 1'b1;
      cyc = 1;
      while (wb_valid !== 1'b1 && cyc < 100) begin
         req_a = 8'(cyc + 20);
         req_b = 8'(cyc + 3);
         req_dest = 3'd0;
         @(negedge clk);
         cyc++;
      end
      req_valid = 1'b0;
      if (cyc >= 100) begin
         tests_run++;
         tests_failed++;
         $display("FAIL hold_timeout: no wb_valid within bound");
      end
      check_wb("hold_7x9", cyc, 8, 8'd63, 3'd7, 1'b0);
   endtask

   initial begin
      tests_run = 0; tests_failed = 0; start_count = 0;
      m_lat = 8; m_level = 1'b0; m_never = 1'b0;
      rst = 1'b1; req_valid = 1'b0; req_a = 8'd0; req_b = 8'd0; req_dest = 3'd0;
      test_reset();
      test_basic_mul();
      test_back_to_back();
      test_bypass();
      test_timeout();
      test_reset_in_wait();
      test_hold_during_busy();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
